sd_reg_bank: RTL
================

SD_REG_BANK -- requirements
Module: sd_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, register and bus width in bits (multiple of 16).
REQ-002 SHALL have parameter ADDR_WIDTH, 5, register address width.
REQ-003 SHALL have parameter NUM_REGS, 29, implemented registers at addresses 0..NUM_REGS-1.
REQ-004 SHALL have parameter CAP_RESET, 32'h0000_0000, reset value of register 16 (Capabilities).
REQ-005 SHALL have parameter VERSION, 16'h0001, reset value of register 19 bits [31:16] (Host_Controller_Version).
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports req input 1 access request; rw input 1 read(1)/write(0); addr input ADDR_WIDTH register index.
REQ-009 SHALL have ports data_in input DATA_WIDTH write data; byte_en input DATA_WIDTH/8 write byte lanes.
REQ-010 SHALL have ports data_out output DATA_WIDTH read data; ack output 1 access done; err output 1 access error, valid with ack.
REQ-011 SHALL have ports resp_we input 1; resp_data input 4*DATA_WIDTH; hardware response load into registers 4..7.
REQ-012 SHALL have ports present_state input DATA_WIDTH live status mirrored into register 9.
REQ-013 SHALL have ports int_set input 16 hardware set pulses for Normal_Interrupt_Status (register 12 [15:0]).
REQ-014 SHALL have ports irq output 1 interrupt; cmd_start output 1 one-cycle command-issue strobe.
REQ-015 SHALL expose each register as a flat output reg_q (NUM_REGS*DATA_WIDTH), register n at bits [n*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-016 SHALL run a handshake FSM with states IDLE, ACK, WAIT.
REQ-017 In IDLE with req=1, SHALL perform the access on that edge and enter ACK; ack=1 for exactly the one ACK cycle with data_out/err valid.
REQ-018 From ACK SHALL enter WAIT; SHALL stay in WAIT while req=1, return to IDLE when req=0; no new access until IDLE (one access per req assertion).
REQ-019 Read SHALL load data_out with the addressed register; data_out SHALL hold its value outside reads.
REQ-020 Write SHALL update only byte lanes with byte_en=1; byte_en=0 SHALL leave the register unchanged while still giving ack.
REQ-021 Registers 4..7, 9, 16..19 SHALL be read-only to the bus: writes ignored, ack given, err=0.
REQ-022 Register 12 SHALL be write-1-to-clear per enabled byte lane; int_set bit =1 SHALL set the bit; same-cycle set and clear SHALL leave the bit set.
REQ-023 resp_we=1 SHALL load registers 4..7 from resp_data (register 4 = least significant word) on that edge.
REQ-024 Register 9 SHALL capture present_state every cycle (one-cycle latency).
REQ-025 addr >= NUM_REGS SHALL return data_out=0 on read, ignore writes, and assert err=1 with ack.
REQ-026 cmd_start SHALL pulse one cycle, the cycle after a write to register 3 with byte_en[3]=1 (Command high byte).
REQ-027 irq SHALL be registered: irq = OR of (reg12[15:0] & reg14[15:0]) | OR of (reg12[31:16] & reg14[31:16]), one cycle after the source change.
REQ-028 Software_Reset (register 11 [31:24]) bits SHALL self-clear one cycle after being written to 1.

Reset
REQ-029 On reset=1, asynchronously: FSM=IDLE, ack=0, err=0, cmd_start=0, irq=0, data_out=0, all registers 0 except register 16=CAP_RESET and register 19[31:16]=VERSION.
REQ-030 reset asserted mid-access SHALL abort it with no register update and no ack after release.

Verification
REQ-031 Write addr 2, data_in 32'hDEAD_BEEF, byte_en 4'b0101, then read addr 2 -> data_out 32'h00AD_00EF, ack one cycle each, err=0.
REQ-032 int_set=16'h0001, reg14=32'h0000_0001 -> irq=1; write addr 12 data 32'h1 byte_en 4'hF -> reg12=0, irq=0 next cycle; repeat with simultaneous int_set bit0 -> bit stays 1.
REQ-033 Write addr 16 data 32'hFFFF_FFFF -> read addr 16 returns CAP_RESET, err=0; read addr 30 -> data_out 0, err=1.
REQ-034 Hold req=1 for 5 cycles on a read -> exactly one ack pulse; second access only after req drops.
REQ-035 Write addr 3 byte_en 4'b1000 -> cmd_start pulse of exactly one cycle; byte_en 4'b0011 -> no pulse.
REQ-036 resp_we=1 with resp_data 128'h4444_4444_3333_3333_2222_2222_1111_1111 -> reads of addr 4..7 return 1111_1111..4444_4444; reset mid-WAIT -> ack=0, registers at reset values.

Source files
------------

// File: rtl/sd_reg_bank.sv
// SD host controller register bank.
// Bus side: req/ack handshake (IDLE -> ACK -> WAIT), one access per req
// assertion, byte-lane writes. Hardware side: response load into regs 4..7,
// present-state mirror into reg 9, interrupt status set pulses into reg 12.
// Field positions (Command high byte, Software_Reset byte) follow the
// 32-bit SD register layout.
module sd_reg_bank #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 5,
  parameter int                    NUM_REGS   = 29,
  parameter logic [DATA_WIDTH-1:0] CAP_RESET  = 32'h0000_0000,
  parameter logic [15:0]           VERSION    = 16'h0001
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req,
  input  logic                           rw,
  input  logic [ADDR_WIDTH-1:0]          addr,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [DATA_WIDTH/8-1:0]        byte_en,
  output logic [DATA_WIDTH-1:0]          data_out,
  output logic                           ack,
  output logic                           err,
  input  logic                           resp_we,
  input  logic [4*DATA_WIDTH-1:0]        resp_data,
  input  logic [DATA_WIDTH-1:0]          present_state,
  input  logic [15:0]                    int_set,
  output logic                           irq,
  output logic                           cmd_start,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_ack;
  logic                  r_err;
  logic                  r_cmd_start;
  logic                  r_irq;

  logic                  w_acc;
  logic                  w_addr_ok;
  logic                  w_wr;
  logic [DATA_WIDTH-1:0] w_bmask;
  logic [DATA_WIDTH-1:0] w_rd_raw;
  logic [DATA_WIDTH-1:0] w_merged;
  logic [NUM_REGS-1:0]   w_wsel;
  logic [DATA_WIDTH-1:0] w_regs [NUM_REGS];

  // An access is taken only from IDLE; WAIT blocks repeats while req stays high.
  assign w_acc     = (r_state == IDLE) && req;
  assign w_addr_ok = ({1'b0, addr} < (ADDR_WIDTH+1)'(NUM_REGS));
  assign w_wr      = w_acc && !rw && w_addr_ok;

  // Expand byte enables to a bit mask.
  always_comb begin
    w_bmask = '0;
    for (int b = 0; b < NB; b++) w_bmask[b*8 +: 8] = {8{byte_en[b]}};
  end

  // Addressed register content (0 for unimplemented addresses) and the
  // byte-merged write value; a write only ever lands on the addressed register.
  always_comb begin
    w_rd_raw = '0;
    for (int n = 0; n < NUM_REGS; n++)
      if (addr == ADDR_WIDTH'(n)) w_rd_raw = w_regs[n];
  end

  assign w_merged = (w_rd_raw & ~w_bmask) | (data_in & w_bmask);

  // One-hot write select per register.
  always_comb begin
    w_wsel = '0;
    for (int n = 0; n < NUM_REGS; n++)
      w_wsel[n] = w_wr && (addr == ADDR_WIDTH'(n));
  end

  // Per-register storage; the register kind is fixed by its index.
  for (genvar n = 0; n < NUM_REGS; n++) begin : g_reg
    logic [DATA_WIDTH-1:0] r_q;

    if (n >= 4 && n <= 7) begin : g_resp
      // Response words: hardware load only, bus writes ignored.
      always_ff @(posedge clk or posedge reset)
        if (reset)        r_q <= '0;
        else if (resp_we) r_q <= resp_data[(n-4)*DATA_WIDTH +: DATA_WIDTH];
    end else if (n == 9) begin : g_pstate
      // Present state mirror, refreshed every cycle.
      always_ff @(posedge clk or posedge reset)
        if (reset) r_q <= '0;
        else       r_q <= present_state;
    end else if (n == 16) begin : g_cap
      assign r_q = CAP_RESET;
    end else if (n == 19) begin : g_ver
      assign r_q = {VERSION, {(DATA_WIDTH-16){1'b0}}};
    end else if (n >= 17 && n <= 18) begin : g_ro0
      assign r_q = '0;
    end else if (n == 12) begin : g_nis
      // W1C per enabled lane; a hardware set wins over a same-cycle clear.
      always_ff @(posedge clk or posedge reset)
        if (reset) r_q <= '0;
        else       r_q <= (r_q & ~(w_wsel[n] ? (data_in & w_bmask) : '0))
                          | {{(DATA_WIDTH-16){1'b0}}, int_set};
    end else if (n == 11) begin : g_swrst
      // Software_Reset byte reads back 1 for one cycle, then self-clears.
      always_ff @(posedge clk or posedge reset)
        if (reset) r_q <= '0;
        else begin
          if (w_wsel[n]) r_q <= w_merged;
          if (!(w_wsel[n] && byte_en[3])) r_q[31:24] <= '0;
        end
    end else begin : g_rw
      // Plain read/write register with byte lanes.
      always_ff @(posedge clk or posedge reset)
        if (reset)          r_q <= '0;
        else if (w_wsel[n]) r_q <= w_merged;
    end

    assign w_regs[n]                            = r_q;
    assign reg_q[n*DATA_WIDTH +: DATA_WIDTH]    = r_q;
  end

  // Handshake FSM with registered ack/err/data_out/cmd_start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ack       <= 1'b0;
      r_err       <= 1'b0;
      r_data_out  <= '0;
      r_cmd_start <= 1'b0;
    end else begin
      r_cmd_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req) begin
            r_state <= ACK;
            r_ack   <= 1'b1;
            r_err   <= !w_addr_ok;
            if (rw) r_data_out <= w_addr_ok ? w_rd_raw : '0;
            r_cmd_start <= !rw && w_addr_ok && (addr == ADDR_WIDTH'(3)) && byte_en[3];
          end
        end
        ACK: begin
          r_state <= WAIT;
          r_ack   <= 1'b0;
          r_err   <= 1'b0;
        end
        WAIT: begin
          if (!req) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Interrupt: any enabled normal or error status bit.
  always_ff @(posedge clk or posedge reset)
    if (reset) r_irq <= 1'b0;
    else       r_irq <= |(w_regs[12] & w_regs[14]);

  assign data_out  = r_data_out;
  assign ack       = r_ack;
  assign err       = r_err;
  assign cmd_start = r_cmd_start;
  assign irq       = r_irq;

endmodule
